uart_rx: RTL and testbench
==========================

# uart_rx

UART receive stage fed by the baud-rate generator's 16x oversampling clock, `baudclk`. It deserialises 8N1 frames from the asynchronous serial line and presents each byte in a holding register with a valid/ack handshake. Errors are flagged per byte: framing, overrun, and optionally parity. Everything runs on `sysclk`; `baudclk` is consumed as an enable source, never as a clock.

## Interface
- `OVERSAMPLE`, default 16: ticks per bit. Must be even, ≥ 4.
- `sysclk` input, 1 bit: system clock. All logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `baudclk` input, 1 bit: oversampling clock from the baud generator, generated in the `sysclk` domain. Each rising edge yields a one-cycle `tick`.
- `rxd` input, 1 bit: serial line, idle high, asynchronous.
- `rx_data` output, 8 bits: received byte. Valid while `rx_valid`.
- `rx_valid` output, 1 bit: byte available. Level signal, held until acknowledged.
- `rx_ack` input, 1 bit: consumer accepts the byte. Only meaningful while `rx_valid`.
- `frame_err` output, 1 bit: the held byte's stop bit sampled 0.
- `parity_err` output, 1 bit: the held byte failed its even-parity check. Constant 0 without `UART_RX_PARITY_EN`.
- `rx_overrun` output, 1 bit: sticky. A byte arrived while the holding register was full.

## Operation
- **Input conditioning.**
  - `rxd` passes through a 2-flop synchroniser, reset to 1, giving `rxd_s`.
  - `baudclk` is registered (reset 0). `tick = baudclk & ~baudclk_q`.
- **States.** IDLE, START, DATA, PARITY (only with the macro), STOP. There is a 4-bit `cnt`, a 3-bit `bitidx` and an 8-bit shift register.
- **IDLE.**
  - `rxd_s==0` → START with `cnt=0`.
  - Start detection does not wait for a tick.
- **START.**
  - Each tick increments `cnt`.
  - At `cnt==OVERSAMPLE/2-1` on a tick (mid start bit):
    - `rxd_s==0` → DATA with `cnt=0`, `bitidx=0`.
    - `rxd_s==1` → IDLE (glitch rejected; nothing reported).
- **DATA.**
  - Each tick increments `cnt`.
  - At `cnt==OVERSAMPLE-1` on a tick: shift `rxd_s` in at the MSB (shift right, LSB first on the wire), set `cnt=0`, increment `bitidx`.
  - After the 8th bit → PARITY if enabled, else STOP.
- **PARITY.** At `cnt==OVERSAMPLE-1` on a tick, capture `rxd_s` as the parity bit → STOP.
- **STOP.** At `cnt==OVERSAMPLE-1` on a tick, sample `rxd_s`, deliver the byte and go to IDLE.
- **Delivery.**
  - If `rx_valid==0`, or `rx_ack` is high in the same cycle:
    - `rx_data` ← shift register.
    - `frame_err` ← `~rxd_s`.
    - `parity_err` ← (XOR of data ^ parity bit) ≠ 0.
    - `rx_valid` ← 1.
  - Otherwise the new byte is discarded and `rx_overrun` ← 1. The held byte and its flags are unchanged.
- **Acknowledge.** `rx_valid & rx_ack` without a simultaneous delivery clears `rx_valid`, `frame_err`, `parity_err` and `rx_overrun` on the next edge. `rx_ack` while `rx_valid==0` is ignored.
- **Data on framing error.** A frame with a stop-bit error is still delivered; `frame_err` marks it. The receiver does not wait for the line to return high. IDLE re-arms on the next low level, so a break condition produces repeated 0x00 bytes with `frame_err` set.

## Timing
- **Reset values.** All outputs 0. State IDLE; counters 0; synchroniser flops 1.
- **Reset mid-frame.** Aborts the frame with no delivery. The next frame is received normally.
- **Sampling latency.** 2 `sysclk` cycles from `rxd` to `rxd_s`.
- **Frame length.** From the first tick after entering START, `rx_valid` rises on the `sysclk` edge that processes tick number `OVERSAMPLE/2 + 9*OVERSAMPLE` = 152 at the default. Add `OVERSAMPLE` if parity is enabled.
- **Default rates.** `baudclk` toggles every 164 `sysclk`, so one tick occurs per 328 `sysclk` and one bit lasts 5248 `sysclk`.
- **Per-cycle work.** At most one bit is sampled per `sysclk` cycle; counters only advance on `tick`.
- **Stalled `baudclk`.** The FSM holds its state indefinitely.

## Configuration
- **`UART_RX_PARITY_EN` defined.**
  - Frames are 8E1; the PARITY state is present.
  - `parity_err` is set when the XOR of the 8 data bits and the parity bit is 1.
- **`UART_RX_PARITY_EN` undefined.**
  - Frames are 8N1; there is no PARITY state.
  - `parity_err` is tied to 0.

## Test plan
- **Reset.** Assert `reset`=0 mid-frame, then release → all outputs 0 and state IDLE. The next 0x3C frame delivers `rx_data`=0x3C.
- **Nominal byte.** Send 0x55 (8N1, 328 `sysclk` per tick) → `rx_valid`=1, `rx_data`=0x55, `frame_err`=0 after tick 152. Pulse `rx_ack` → `rx_valid`=0 on the next cycle.
- **Glitch rejection.** Drive `rxd` low for 4 ticks, then high → no `rx_valid`, FSM back in IDLE. A following 0x81 frame is received correctly.
- **Framing error.** Send 0xA3 with the stop bit 0 → `rx_valid`=1, `rx_data`=0xA3, `frame_err`=1.
- **Overrun.** Send 0x12 then 0x34 with no ack → `rx_data`=0x12, `rx_overrun`=1. `rx_ack` → `rx_valid`=0, `rx_overrun`=0. Separately, an ack in the same cycle as delivery → `rx_data`=0x34, `rx_valid` stays 1, no overrun.
- **Parity (macro defined).**
  - 0x07 with parity bit 0 → `parity_err`=1.
  - 0x07 with parity bit 1 → `parity_err`=0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx.
//   master : the receiver; drives the held byte, its flags and rx_valid, samples rx_ack.
//   slave  : the consumer; samples the byte and flags, drives rx_ack.
// Signals:
//   rx_data    [7:0] received byte, valid while rx_valid
//   rx_valid         byte available, held until acknowledged
//   rx_ack           consumer accepts the held byte
//   frame_err        held byte's stop bit sampled 0
//   parity_err       held byte failed its even-parity check
//   rx_overrun       sticky: a byte arrived while the holding register was full
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       parity_err;
  logic       rx_overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output rx_overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  rx_overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) sampled
// with a 16x-style oversampling enable and holds each byte behind a valid/ack handshake.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and the parity_err check).
// Ports:
//   sysclk   system clock, all logic on its rising edge
//   reset    asynchronous active-low reset
//   baudclk  oversampling clock from the baud generator, used only as an edge-detected enable
//   rxd      asynchronous serial line, idle high
//   rx       uart_rx_if.master: rx_data/rx_valid/rx_ack/frame_err/parity_err/rx_overrun
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic      sysclk,
  input  logic      reset,
  input  logic      baudclk,
  input  logic      rxd,
  uart_rx_if.master rx
);

  localparam logic [3:0] CntHalf = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] CntLast = 4'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e     state_q, state_d;
  logic       rxd_meta, rxd_s;
  logic       baudclk_q, tick;
  logic [3:0] cnt_q;
  logic [2:0] bitidx_q;
  logic [7:0] shreg_q;
  logic       parity_bad;

  logic       cnt_clr, cnt_inc, bitidx_clr, shift_en, deliver;

  logic [7:0] data_q;
  logic       valid_q, ferr_q, perr_q, ovr_q;

  // Input conditioning: line synchroniser and baudclk rising-edge detect.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rxd_meta  <= 1'b1;
      rxd_s     <= 1'b1;
      baudclk_q <= 1'b0;
    end else begin
      rxd_meta  <= rxd;
      rxd_s     <= rxd_meta;
      baudclk_q <= baudclk;
    end
  end

  assign tick = baudclk & ~baudclk_q;

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rxd_s) state_d = StStart;
      // Mid start bit: a high line here was only a glitch.
      StStart: if (tick && cnt_q == CntHalf) state_d = rxd_s ? StIdle : StData;
      StData: begin
        if (tick && cnt_q == CntLast && bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (tick && cnt_q == CntLast) state_d = StStop;
`endif
      // No wait for the line to go high again: a break yields repeated framing errors.
      StStop:  if (tick && cnt_q == CntLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath control strobes.
  always_comb begin
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    bitidx_clr = 1'b0;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    unique case (state_q)
      StIdle: cnt_clr = 1'b1;
      StStart: begin
        if (tick) begin
          if (cnt_q == CntHalf) begin
            cnt_clr    = 1'b1;
            bitidx_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (cnt_q == CntLast) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (cnt_q == CntLast) cnt_clr = 1'b1;
          else                  cnt_inc = 1'b1;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (cnt_q == CntLast) begin
            cnt_clr = 1'b1;
            deliver = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit counters and LSB-first shift register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
      if (bitidx_clr)    bitidx_q <= '0;
      else if (shift_en) bitidx_q <= bitidx_q + 3'd1;
      if (shift_en) shreg_q <= {rxd_s, shreg_q[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (state_q == StParity && tick && cnt_q == CntLast) begin
      par_q <= rxd_s;
    end
  end

  assign parity_bad = ^{shreg_q, par_q};
`else
  assign parity_bad = 1'b0;
`endif

  // Holding register. An ack in the delivery cycle frees the slot for the new byte.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (deliver) begin
      if (!valid_q || rx.rx_ack) begin
        data_q  <= shreg_q;
        ferr_q  <= ~rxd_s;
        perr_q  <= parity_bad;
        valid_q <= 1'b1;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && rx.rx_ack) begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.frame_err  = ferr_q;
  assign rx.parity_err = perr_q;
  assign rx.rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: the bench owns baudclk and emits each tick explicitly, so the tick
// that samples the stop bit is known exactly. Expected bytes go into a scoreboard queue
// when a frame is sent and are popped when rx_valid is seen.
module tb_uart_rx;
  localparam int Os = 16;

  logic sysclk  = 1'b0;
  logic reset   = 1'b0;
  logic baudclk = 1'b0;
  logic rxd     = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(Os)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .baudclk (baudclk),
    .rxd     (rxd),
    .rx      (bus.master)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // One baudclk rising edge; optional rx_ack in exactly the cycle the tick is processed.
  task automatic tick_once(input logic ack);
    @(negedge sysclk);
    baudclk    = 1'b1;
    bus.rx_ack = ack;
    @(negedge sysclk);
    bus.rx_ack = 1'b0;
    @(negedge sysclk);
    baudclk = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once(1'b0);
  endtask

  // Start bit, 8 data bits LSB first, [parity], stop. Each bit spans Os ticks; the last
  // bit stops at its sampling tick.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit ack_last, input bit push, input bit chk_lat);
    logic [10:0] bits;
    int          nb;
    exp_t        e;
`ifdef UART_RX_PARITY_EN
    bits   = {stop, par, d, 1'b0};
    nb     = 11;
    e.perr = ^{d, par};
`else
    bits   = {par, stop, d, 1'b0};
    nb     = 10;
    e.perr = 1'b0;
`endif
    e.data = d;
    e.ferr = ~stop;
    if (push) exp_q.push_back(e);
    // Line low with baudclk stalled: the receiver sits in START with cnt=0.
    @(negedge sysclk);
    rxd = 1'b0;
    repeat (4) @(negedge sysclk);
    for (int k = 0; k < nb; k++) begin
      rxd = bits[k];
      if (k < nb - 1) begin
        ticks(Os);
      end else begin
        ticks(Os / 2 - 1);
        if (chk_lat) check("no_valid_before_last_tick", {31'd0, bus.rx_valid}, 32'd0);
        tick_once(ack_last);
      end
    end
    rxd = 1'b1;
    // Idle ticks also flush a START entered off a low stop bit.
    ticks(12);
  endtask

  task automatic expect_byte();
    int   w;
    exp_t e;
    w = 0;
    while (!bus.rx_valid && w < 50) begin
      @(negedge sysclk);
      w++;
    end
    check("rx_valid_seen", {31'd0, bus.rx_valid}, 32'd1);
    check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
      check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.ferr});
      check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
    end
  endtask

  task automatic ack_pulse();
    @(negedge sysclk);
    bus.rx_ack = 1'b1;
    @(negedge sysclk);
    bus.rx_ack = 1'b0;
    check("ack_clears_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("ack_clears_flags", {29'd0, bus.frame_err, bus.parity_err, bus.rx_overrun}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_ack = 1'b0;
    reset      = 1'b0;
    repeat (3) @(negedge sysclk);
    check("reset_outputs", {20'd0, bus.rx_data, bus.rx_valid, bus.frame_err, bus.parity_err,
                            bus.rx_overrun}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);

    // Nominal byte, including the stop-tick latency.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_byte();
    check("no_overrun_nominal", {31'd0, bus.rx_overrun}, 32'd0);
    ack_pulse();

    // Short low glitch is rejected at mid start bit.
    @(negedge sysclk);
    rxd = 1'b0;
    ticks(4);
    rxd = 1'b1;
    ticks(12);
    check("glitch_no_valid", {31'd0, bus.rx_valid}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_byte();
    ack_pulse();

    // Framing error: byte still delivered, flagged.
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_byte();
    ack_pulse();

    // Overrun: second byte discarded, first one held.
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_byte();
    check("overrun_set", {31'd0, bus.rx_overrun}, 32'd1);
    ack_pulse();

    // Ack in the delivery cycle: new byte replaces the old, no overrun.
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_byte();
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_byte();
    check("no_overrun_same_cycle_ack", {31'd0, bus.rx_overrun}, 32'd0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_byte();
    ack_pulse();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_byte();
    ack_pulse();
`endif

    // Reset mid-frame with a byte held: everything clears, next frame is normal.
    send_frame(8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge sysclk);
    rxd = 1'b0;
    ticks(40);
    reset = 1'b0;
    #1;
    check("reset_mid_frame", {20'd0, bus.rx_data, bus.rx_valid, bus.frame_err, bus.parity_err,
                              bus.rx_overrun}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_byte();
    ack_pulse();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
